// File: rtl/sync_barrier.sv
// sync_barrier: two-core rendezvous barrier with a wrapping generation counter.
// Define SYNC_TIMEOUT_EN to release a lone waiting core after TIMEOUT_CYCLES.
module sync_barrier #(
    parameter int unsigned GEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             halted0,
    input  logic             halted1,
    output logic             wait0,
    output logic             wait1,
    output logic             go0,
    output logic             go1,
    output logic [GEN_W-1:0] gen,
    output logic [2:0]       state,
    output logic             timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT0   = 3'd1,
        WAIT1   = 3'd2,
        RELEASE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t cur;
    state_t nxt;
    logic   arrived0;
    logic   arrived1;
    logic   nxt_arrived0;
    logic   nxt_arrived1;
    logic   nxt_wait;

`ifdef SYNC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             in_wait;
    logic [CNT_W-1:0] wait_cnt;
    logic             tmo_hit;
    logic             tmo_fire;

    assign in_wait = (cur == WAIT0) || (cur == WAIT1);
    assign tmo_hit = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign state = cur;

    // Next-state and arrival bookkeeping; a halted core counts as present only if it never arrived.
    always_comb begin
        nxt          = cur;
        nxt_arrived0 = arrived0;
        nxt_arrived1 = arrived1;
`ifdef SYNC_TIMEOUT_EN
        tmo_fire     = 1'b0;
`endif
        case (cur)
            IDLE: begin
                nxt_arrived0 = req0;
                nxt_arrived1 = req1;
                if (req0 && req1)
                    nxt = RELEASE;
                else if (req0)
                    nxt = halted1 ? RELEASE : WAIT0;
                else if (req1)
                    nxt = halted0 ? RELEASE : WAIT1;
            end
            WAIT0: begin
                nxt_arrived1 = req1;
                if (req1 || halted1)
                    nxt = RELEASE;
            end
            WAIT1: begin
                nxt_arrived0 = req0;
                if (req0 || halted0)
                    nxt = RELEASE;
            end
            RELEASE: nxt = DRAIN;
            DRAIN: begin
                if (!req0 && !req1) begin
                    nxt          = IDLE;
                    nxt_arrived0 = 1'b0;
                    nxt_arrived1 = 1'b0;
                end
            end
            default: begin
                nxt          = IDLE;
                nxt_arrived0 = 1'b0;
                nxt_arrived1 = 1'b0;
            end
        endcase
`ifdef SYNC_TIMEOUT_EN
        if (tmo_hit && ((nxt == WAIT0) || (nxt == WAIT1))) begin
            nxt      = RELEASE;
            tmo_fire = 1'b1;
        end
`endif
    end

    assign nxt_wait = (nxt == WAIT0) || (nxt == WAIT1);

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= IDLE;
            arrived0 <= 1'b0;
            arrived1 <= 1'b0;
            wait0    <= 1'b0;
            wait1    <= 1'b0;
            go0      <= 1'b0;
            go1      <= 1'b0;
            gen      <= '0;
        end else begin
            cur      <= nxt;
            arrived0 <= nxt_arrived0;
            arrived1 <= nxt_arrived1;
            wait0    <= nxt_wait && nxt_arrived0;
            wait1    <= nxt_wait && nxt_arrived1;
            go0      <= (nxt == RELEASE) && nxt_arrived0;
            go1      <= (nxt == RELEASE) && nxt_arrived1;
            if (nxt == RELEASE)
                gen <= gen + GEN_W'(1);
        end
    end

`ifdef SYNC_TIMEOUT_EN
    // Wait-cycle counter runs only while the FSM stays in a WAIT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= (in_wait && nxt_wait) ? wait_cnt + CNT_W'(1) : '0;
            if (tmo_fire)
                timeout <= 1'b1;
        end
    end
`else
    // TIMEOUT_CYCLES has no effect in this build; the flag is constant low.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_sync_barrier.sv
// Self-checking bench for sync_barrier: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the barrier rules.
module tb_sync_barrier;

    localparam int unsigned GEN_W = 3;
    localparam int unsigned TMO   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic             halted0 = 1'b0;
    logic             halted1 = 1'b0;
    logic             wait0;
    logic             wait1;
    logic             go0;
    logic             go1;
    logic [GEN_W-1:0] gen;
    logic [2:0]       state;
    logic             timeout;

    int n_checks = 0;
    int n_errors = 0;

    sync_barrier #(.GEN_W(GEN_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .halted0(halted0), .halted1(halted1),
        .wait0(wait0), .wait1(wait1),
        .go0(go0), .go1(go1),
        .gen(gen), .state(state), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: who has arrived, whether a release or drain is under way.
    bit          m_arr0, m_arr1, m_fire, m_drain, m_tmo;
    int unsigned m_gen, m_waited;

    task automatic model_reset();
        m_arr0 = 0; m_arr1 = 0; m_fire = 0; m_drain = 0; m_tmo = 0;
        m_gen = 0; m_waited = 0;
    endtask

    task automatic model_step(input bit r0, input bit r1, input bit h0, input bit h1);
        bit a0, a1, done;
        if (m_fire) begin
            m_fire  = 0;
            m_drain = 1;
        end else if (m_drain) begin
            if (!r0 && !r1) begin
                m_drain = 0; m_arr0 = 0; m_arr1 = 0;
            end
        end else begin
            a0 = m_arr0 | r0;
            a1 = m_arr1 | r1;
            if (a0 || a1) begin
                done = (a0 || h0) && (a1 || h1);
                if (m_arr0 || m_arr1) m_waited++;
                else m_waited = 0;
`ifdef SYNC_TIMEOUT_EN
                if (!done && m_waited >= TMO) begin
                    done  = 1;
                    m_tmo = 1;
                end
`endif
                if (done) begin
                    m_fire = 1;
                    m_gen  = (m_gen + 1) % (1 << GEN_W);
                end
            end
            m_arr0 = a0;
            m_arr1 = a1;
        end
    endtask

    function automatic logic [2:0] model_state();
        if (m_fire)  return 3'd3;
        if (m_drain) return 3'd4;
        if (m_arr0)  return 3'd1;
        if (m_arr1)  return 3'd2;
        return 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(req0, req1, halted0, halted1);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 0; req1 = 0; halted0 = 0; halted1 = 0;
        repeat (2) tick();
        n_checks++;
        if ({state, wait0, wait1, go0, go1, timeout, gen} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected 0", {state, wait0, wait1, go0, go1, timeout, gen});
        end
        rst = 1'b0; req0 = 1; req1 = 1;
        tick();
        n_checks++;
        if ({state, wait0, wait1, go0, go1} !== {3'd3, 4'b0011} || gen !== 3'd1) begin
            n_errors++;
            $display("FAIL first_barrier: got st=%0d w=%b%b go=%b%b gen=%0d expected st=3 w=00 go=11 gen=1",
                     state, wait0, wait1, go0, go1, gen);
        end
        req0 = 0; req1 = 0;
        tick();
        n_checks++;
        if ({state, go0, go1} !== {3'd4, 2'b00}) begin
            n_errors++;
            $display("FAIL release_to_drain: got st=%0d go=%b%b expected st=4 go=00", state, go0, go1);
        end
        tick();
        n_checks++;
        if (state !== 3'd0 || gen !== 3'd1) begin
            n_errors++;
            $display("FAIL drain_to_idle: got st=%0d gen=%0d expected st=0 gen=1", state, gen);
        end
    endtask

    task automatic test_late_arrival();
        req1 = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if ({state, wait0, wait1, go0, go1} !== {3'd2, 4'b0100}) begin
                n_errors++;
                $display("FAIL late_wait1 c%0d: got st=%0d w=%b%b go=%b%b expected st=2 w=01 go=00",
                         i, state, wait0, wait1, go0, go1);
            end
        end
        req0 = 1;
        tick();
        n_checks++;
        if ({state, wait0, wait1, go0, go1} !== {3'd3, 4'b0011} || gen !== 3'd2) begin
            n_errors++;
            $display("FAIL late_release: got st=%0d w=%b%b go=%b%b gen=%0d expected st=3 w=00 go=11 gen=2",
                     state, wait0, wait1, go0, go1, gen);
        end
        req0 = 0; req1 = 0;
        repeat (2) tick();
    endtask

    task automatic test_halted();
        halted1 = 1; req0 = 1;
        tick();
        n_checks++;
        if ({state, wait0, wait1, go0, go1} !== {3'd3, 4'b0010} || gen !== 3'd3) begin
            n_errors++;
            $display("FAIL halted_peer: got st=%0d w=%b%b go=%b%b gen=%0d expected st=3 w=00 go=10 gen=3",
                     state, wait0, wait1, go0, go1, gen);
        end
        req0 = 0;
        repeat (2) tick();
        halted0 = 1;
        repeat (3) tick();
        n_checks++;
        if ({state, go0, go1} !== {3'd0, 2'b00} || gen !== 3'd3) begin
            n_errors++;
            $display("FAIL both_halted_idle: got st=%0d go=%b%b gen=%0d expected st=0 go=00 gen=3",
                     state, go0, go1, gen);
        end
        halted0 = 0; halted1 = 0;
    endtask

    task automatic test_halted_arrived();
        req0 = 1;
        tick();
        halted0 = 1;
        tick();
        n_checks++;
        if ({state, wait0, wait1, go0, go1} !== {3'd1, 4'b1000}) begin
            n_errors++;
            $display("FAIL halted_after_arrival: got st=%0d w=%b%b go=%b%b expected st=1 w=10 go=00",
                     state, wait0, wait1, go0, go1);
        end
        req1 = 1;
        tick();
        n_checks++;
        if ({state, go0, go1} !== {3'd3, 2'b11} || gen !== 3'd4) begin
            n_errors++;
            $display("FAIL arrived_release: got st=%0d go=%b%b gen=%0d expected st=3 go=11 gen=4",
                     state, go0, go1, gen);
        end
        req0 = 0; req1 = 0; halted0 = 0;
        repeat (2) tick();
    endtask

    task automatic test_drain_hold();
        req0 = 1; req1 = 1;
        tick();
        req1 = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if ({state, go0, go1} !== {3'd4, 2'b00} || gen !== 3'd5) begin
                n_errors++;
                $display("FAIL drain_hold c%0d: got st=%0d go=%b%b gen=%0d expected st=4 go=00 gen=5",
                         i, state, go0, go1, gen);
            end
        end
        req0 = 0;
        tick();
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("FAIL drain_exit: got st=%0d expected 0", state);
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1;
        tick();
        rst = 1;
        #1;
        model_reset();
        n_checks++;
        if ({state, wait0, go0, go1} !== {3'd0, 3'b000} || gen !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_in_wait: got st=%0d w0=%b go=%b%b gen=%0d expected st=0 w0=0 go=00 gen=0",
                     state, wait0, go0, go1, gen);
        end
        tick();
        req0 = 0; rst = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if ({state, go0, go1} !== {3'd0, 2'b00}) begin
                n_errors++;
                $display("FAIL no_go_after_reset c%0d: got st=%0d go=%b%b expected st=0 go=00",
                         i, state, go0, go1);
            end
        end
    endtask

    task automatic test_timeout();
        req0 = 1;
        tick();
`ifdef SYNC_TIMEOUT_EN
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if ({state, wait0, go0, timeout} !== {3'd1, 3'b100}) begin
                n_errors++;
                $display("FAIL tmo_waiting c%0d: got st=%0d w0=%b go0=%b tmo=%b expected st=1 w0=1 go0=0 tmo=0",
                         i, state, wait0, go0, timeout);
            end
        end
        tick();
        n_checks++;
        if ({state, wait0, go0, go1, timeout} !== {3'd3, 4'b0101}) begin
            n_errors++;
            $display("FAIL tmo_release: got st=%0d w0=%b go=%b%b tmo=%b expected st=3 w0=0 go=10 tmo=1",
                     state, wait0, go0, go1, timeout);
        end
        req0 = 0;
        repeat (2) tick();
        n_checks++;
        if ({state, timeout} !== {3'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL tmo_sticky: got st=%0d tmo=%b expected st=0 tmo=1", state, timeout);
        end
`else
        repeat (20) tick();
        n_checks++;
        if ({state, wait0, go0, timeout} !== {3'd1, 3'b100}) begin
            n_errors++;
            $display("FAIL wait_forever: got st=%0d w0=%b go0=%b tmo=%b expected st=1 w0=1 go0=0 tmo=0",
                     state, wait0, go0, timeout);
        end
        req1 = 1;
        tick();
        req0 = 0; req1 = 0;
        repeat (2) tick();
`endif
    endtask

    task automatic test_random();
        bit          pend[2];
        bit          ps[2];
        int          hold[2];
        bit          r[2], g[2], h[2], nr[2];
        int          quiet;
        logic [10:0] act, exp;
        pend = '{0, 0}; hold = '{0, 0}; quiet = 2;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = 1'b0;
            if (cyc % 300 == 299) begin
                rst = 1; req0 = 0; req1 = 0; halted0 = 0; halted1 = 0;
                pend = '{0, 0}; hold = '{0, 0}; quiet = 2;
            end else begin
                r = '{req0, req1}; g = '{go0, go1}; h = '{halted0, halted1};
                ps = pend;
                for (int c = 0; c < 2; c++) begin
                    nr[c] = r[c];
                    if (pend[c]) begin
                        if (g[c]) begin
                            pend[c] = 0;
                            hold[c] = int'($urandom_range(0, 3));
                            if (hold[c] == 0) nr[c] = 0;
                        end
                    end else if (r[c]) begin
                        if (hold[c] == 0) nr[c] = 0;
                        else hold[c]--;
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if (!ps[c] && !r[c] && !h[c]) begin
                        if ((quiet >= 2 || (ps[1-c] && !g[1-c])) && $urandom_range(0, 3) == 0) begin
                            nr[c]   = 1;
                            pend[c] = 1;
                        end else if ($urandom_range(0, 199) == 0) begin
                            h[c] = 1;
                        end
                    end
                end
                req0 = nr[0]; req1 = nr[1]; halted0 = h[0]; halted1 = h[1];
            end
            tick();
            if (!req0 && !req1) quiet++;
            else quiet = 0;
            act = {state, wait0, wait1, go0, go1, timeout, gen};
            exp = {model_state(),
                   !m_fire && !m_drain && m_arr0, !m_fire && !m_drain && m_arr1,
                   m_fire && m_arr0, m_fire && m_arr1, m_tmo, GEN_W'(m_gen)};
            n_checks++;
            if (act !== exp) begin
                n_errors++;
                $display("FAIL random cyc=%0d {st,w0,w1,g0,g1,tmo,gen}: got %h expected %h", cyc, act, exp);
            end
            n_checks++;
            if (((go0 & wait0) | (go1 & wait1)) !== 1'b0) begin
                n_errors++;
                $display("FAIL go_wait_overlap cyc=%0d: got go=%b%b wait=%b%b expected no overlap",
                         cyc, go0, go1, wait0, wait1);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_late_arrival();
        test_halted();
        test_halted_arrived();
        test_drain_hold();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
